// File: rtl/sys_ctrl_tx_if.sv
// Bus between the system controller's TX side, its result sources and UART_TX.
// The slave modport is the controller's view; master is the surrounding environment.
interface sys_ctrl_tx_if #(
    parameter int DATA_WIDTH    = 8,
    parameter int ALU_OUT_WIDTH = 2 * DATA_WIDTH
);
    logic [DATA_WIDTH-1:0]    RdData;
    logic                     RdData_Valid;
    logic [ALU_OUT_WIDTH-1:0] ALU_OUT;
    logic                     OUT_Valid;
    logic                     Busy;
    logic [DATA_WIDTH-1:0]    TX_P_DATA;
    logic                     TX_D_VLD;
    logic                     OVF_ERR;

    modport master (
        output RdData, RdData_Valid, ALU_OUT, OUT_Valid, Busy,
        input  TX_P_DATA, TX_D_VLD, OVF_ERR
    );

    modport slave (
        input  RdData, RdData_Valid, ALU_OUT, OUT_Valid, Busy,
        output TX_P_DATA, TX_D_VLD, OVF_ERR
    );
endinterface

// File: rtl/sys_ctrl_tx.sv
// Queues register-file reads and ALU results and feeds them to UART_TX one byte
// at a time; ALU results go out low byte then high byte, back to back.
module sys_ctrl_tx #(
    parameter int DATA_WIDTH    = 8,
    parameter int ALU_OUT_WIDTH = 2 * DATA_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    sys_ctrl_tx_if.slave     bus
);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT_ACK,
        WAIT_DONE
    } state_t;

    typedef enum logic [1:0] {
        SEL_RF,
        SEL_ALU_LO,
        SEL_ALU_HI
    } sel_t;

    state_t state;
    state_t next_state;
    sel_t   sel;
    sel_t   next_sel;

    logic                     rf_pend;
    logic                     alu_pend;
    logic [DATA_WIDTH-1:0]    rf_buf;
    logic [ALU_OUT_WIDTH-1:0] alu_buf;

    logic                     rf_clear;
    logic                     alu_clear;
    logic                     tx_vld_nxt;
    logic [DATA_WIDTH-1:0]    tx_data_nxt;

    // Outputs are registered off next_state so the strobe lands in the SEND cycle itself.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= IDLE;
            sel           <= SEL_RF;
            bus.TX_P_DATA <= '0;
            bus.TX_D_VLD  <= 1'b0;
        end else begin
            state         <= next_state;
            sel           <= next_sel;
            bus.TX_P_DATA <= tx_data_nxt;
            bus.TX_D_VLD  <= tx_vld_nxt;
        end
    end

    always_comb begin
        next_state = state;
        next_sel   = sel;
        case (state)
            IDLE: begin
                if (!bus.Busy) begin
                    if (rf_pend) begin
                        next_sel   = SEL_RF;
                        next_state = SEND;
                    end else if (alu_pend) begin
                        next_sel   = SEL_ALU_LO;
                        next_state = SEND;
                    end
                end
            end
            SEND: begin
                next_state = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (bus.Busy) begin
                    next_state = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (!bus.Busy) begin
                    case (sel)
                        SEL_ALU_LO: begin
                            next_sel   = SEL_ALU_HI;
                            next_state = SEND;
                        end
                        default: begin
                            next_state = IDLE;
                        end
                    endcase
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_comb begin
        rf_clear    = (state == WAIT_DONE) && !bus.Busy && (sel == SEL_RF);
        alu_clear   = (state == WAIT_DONE) && !bus.Busy && (sel == SEL_ALU_HI);
        tx_vld_nxt  = (next_state == SEND);
        tx_data_nxt = bus.TX_P_DATA;
        if (next_state == SEND) begin
            case (next_sel)
                SEL_RF:     tx_data_nxt = rf_buf;
                SEL_ALU_LO: tx_data_nxt = alu_buf[DATA_WIDTH-1:0];
                default:    tx_data_nxt = alu_buf[ALU_OUT_WIDTH-1 -: DATA_WIDTH];
            endcase
        end
    end

    // A slot being released on this edge counts as empty, so a same-edge strobe refills it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rf_pend     <= 1'b0;
            alu_pend    <= 1'b0;
            rf_buf      <= '0;
            alu_buf     <= '0;
            bus.OVF_ERR <= 1'b0;
        end else begin
            if (bus.RdData_Valid && (!rf_pend || rf_clear)) begin
                rf_buf  <= bus.RdData;
                rf_pend <= 1'b1;
            end else if (rf_clear) begin
                rf_pend <= 1'b0;
            end

            if (bus.OUT_Valid && (!alu_pend || alu_clear)) begin
                alu_buf  <= bus.ALU_OUT;
                alu_pend <= 1'b1;
            end else if (alu_clear) begin
                alu_pend <= 1'b0;
            end

            if ((bus.RdData_Valid && rf_pend && !rf_clear) ||
                (bus.OUT_Valid && alu_pend && !alu_clear)) begin
                bus.OVF_ERR <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sys_ctrl_tx.sv
// Directed bench for sys_ctrl_tx: a hand-driven Busy stands in for UART_TX and
// every transmitted byte, pulse width and error flag is checked against fixed values.
module tb_sys_ctrl_tx;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    sys_ctrl_tx_if bus ();

    sys_ctrl_tx dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Present strobes for exactly one rising edge; returns on the following falling edge.
    task automatic applyStimulus(input logic rf_v, input logic [7:0] rf_d, input logic alu_v, input logic [15:0] alu_d);
        bus.RdData       = rf_d;
        bus.RdData_Valid = rf_v;
        bus.ALU_OUT      = alu_d;
        bus.OUT_Valid    = alu_v;
        @(negedge clk);
        bus.RdData_Valid = 1'b0;
        bus.OUT_Valid    = 1'b0;
    endtask

    task automatic waitByte(input string tag, input logic [7:0] expected);
        int n = 0;
        while (bus.TX_D_VLD !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, "_vld"}, 16'(bus.TX_D_VLD), 16'd1);
        checkOutput({tag, "_data"}, 16'(bus.TX_P_DATA), 16'(expected));
        @(negedge clk);
        checkOutput({tag, "_pulse"}, 16'(bus.TX_D_VLD), 16'd0);
    endtask

    // UART_TX model: Busy rises after a delay and stays high for len cycles.
    task automatic busyPulse(input string tag, input int delay, input int len, input logic [7:0] last);
        logic vld_seen = 1'b0;
        logic data_moved = 1'b0;
        repeat (delay) @(negedge clk);
        bus.Busy = 1'b1;
        repeat (len) begin
            @(negedge clk);
            vld_seen   = vld_seen | bus.TX_D_VLD;
            data_moved = data_moved | (bus.TX_P_DATA !== last);
        end
        bus.Busy = 1'b0;
        checkOutput({tag, "_busy_no_vld"}, 16'(vld_seen), 16'd0);
        checkOutput({tag, "_busy_hold"}, 16'(data_moved), 16'd0);
    endtask

    task automatic expectQuiet(input string tag, input int cycles);
        logic vld_seen = 1'b0;
        repeat (cycles) begin
            @(negedge clk);
            vld_seen = vld_seen | bus.TX_D_VLD;
        end
        checkOutput(tag, 16'(vld_seen), 16'd0);
    endtask

    task automatic doReset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        checkOutput("rst_vld", 16'(bus.TX_D_VLD), 16'd0);
        checkOutput("rst_data", 16'(bus.TX_P_DATA), 16'd0);
        checkOutput("rst_ovf", 16'(bus.OVF_ERR), 16'd0);
    endtask

    initial begin
        reset            = 1'b0;
        bus.RdData       = '0;
        bus.RdData_Valid = 1'b0;
        bus.ALU_OUT      = '0;
        bus.OUT_Valid    = 1'b0;
        bus.Busy         = 1'b0;

        // Strobes presented during reset must be ignored.
        @(negedge clk);
        applyStimulus(1'b1, 8'hA5, 1'b1, 16'h1234);
        doReset();
        expectQuiet("rst_strobe_ignored", 10);

        $display("[TB] RF read 0x5A");
        applyStimulus(1'b1, 8'h5A, 1'b0, 16'h0);
        checkOutput("rf_lat_early", 16'(bus.TX_D_VLD), 16'd0);
        @(negedge clk);
        checkOutput("rf_lat_vld", 16'(bus.TX_D_VLD), 16'd1);
        checkOutput("rf_lat_data", 16'(bus.TX_P_DATA), 16'h5A);
        @(negedge clk);
        checkOutput("rf_pulse", 16'(bus.TX_D_VLD), 16'd0);
        busyPulse("rf", 7, 4, 8'h5A);
        expectQuiet("rf_idle", 8);
        checkOutput("rf_ovf", 16'(bus.OVF_ERR), 16'd0);

        $display("[TB] ALU result 0xBEEF");
        applyStimulus(1'b0, 8'h0, 1'b1, 16'hBEEF);
        waitByte("alu_lo", 8'hEF);
        busyPulse("alu_lo", 2, 6, 8'hEF);
        waitByte("alu_hi", 8'hBE);
        busyPulse("alu_hi", 1, 3, 8'hBE);
        expectQuiet("alu_idle", 8);

        $display("[TB] simultaneous RF 0x11 and ALU 0x3344");
        applyStimulus(1'b1, 8'h11, 1'b1, 16'h3344);
        waitByte("sim_rf", 8'h11);
        busyPulse("sim_rf", 1, 3, 8'h11);
        waitByte("sim_lo", 8'h44);
        busyPulse("sim_lo", 1, 3, 8'h44);
        waitByte("sim_hi", 8'h33);
        busyPulse("sim_hi", 1, 3, 8'h33);
        expectQuiet("sim_idle", 6);
        checkOutput("sim_ovf", 16'(bus.OVF_ERR), 16'd0);

        $display("[TB] RF overflow");
        applyStimulus(1'b1, 8'h11, 1'b0, 16'h0);
        applyStimulus(1'b1, 8'h22, 1'b0, 16'h0);
        waitByte("ovf_rf", 8'h11);
        busyPulse("ovf_rf", 1, 3, 8'h11);
        expectQuiet("ovf_dropped", 10);
        checkOutput("ovf_set", 16'(bus.OVF_ERR), 16'd1);
        repeat (5) @(negedge clk);
        checkOutput("ovf_sticky", 16'(bus.OVF_ERR), 16'd1);
        doReset();

        $display("[TB] reset during low-byte WAIT_DONE");
        applyStimulus(1'b0, 8'h0, 1'b1, 16'hBEEF);
        waitByte("rst_mid_lo", 8'hEF);
        repeat (2) @(negedge clk);
        bus.Busy = 1'b1;
        repeat (3) @(negedge clk);
        reset            = 1'b0;
        bus.RdData       = 8'h77;
        bus.RdData_Valid = 1'b1;
        repeat (2) @(negedge clk);
        reset            = 1'b1;
        bus.RdData_Valid = 1'b0;
        bus.Busy         = 1'b0;
        checkOutput("rst_mid_vld", 16'(bus.TX_D_VLD), 16'd0);
        checkOutput("rst_mid_data", 16'(bus.TX_P_DATA), 16'd0);
        checkOutput("rst_mid_ovf", 16'(bus.OVF_ERR), 16'd0);
        expectQuiet("rst_mid_no_resume", 15);

        $display("[TB] refill on high-byte exit edge");
        applyStimulus(1'b0, 8'h0, 1'b1, 16'h0A0B);
        waitByte("ref_lo", 8'h0B);
        busyPulse("ref_lo", 2, 3, 8'h0B);
        waitByte("ref_hi", 8'h0A);
        repeat (2) @(negedge clk);
        bus.Busy = 1'b1;
        repeat (3) @(negedge clk);
        bus.Busy      = 1'b0;
        bus.ALU_OUT   = 16'h0102;
        bus.OUT_Valid = 1'b1;
        @(negedge clk);
        bus.OUT_Valid = 1'b0;
        waitByte("ref_new_lo", 8'h02);
        busyPulse("ref_new_lo", 1, 3, 8'h02);
        waitByte("ref_new_hi", 8'h01);
        busyPulse("ref_new_hi", 1, 3, 8'h01);
        expectQuiet("ref_idle", 6);
        checkOutput("ref_ovf", 16'(bus.OVF_ERR), 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sys_ctrl_tx.md
SYS_CTRL_TX -- requirements
Module: sys_ctrl_tx

Interface
REQ-001 The parameter DATA_WIDTH SHALL default to 8 and set the UART frame payload width.
REQ-002 The parameter ALU_OUT_WIDTH SHALL default to 16 and set the ALU result width, fixed at 2*DATA_WIDTH.
REQ-003 Port clk SHALL be an input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-004 Port reset SHALL be an input, 1 bit: synchronous, active-low reset.
REQ-005 Port RdData SHALL be an input, DATA_WIDTH bits: register-file read data.
REQ-006 Port RdData_Valid SHALL be an input, 1 bit: one-cycle strobe qualifying RdData.
REQ-007 Port ALU_OUT SHALL be an input, ALU_OUT_WIDTH bits: ALU result.
REQ-008 Port OUT_Valid SHALL be an input, 1 bit: one-cycle strobe qualifying ALU_OUT.
REQ-009 Port Busy SHALL be an input, 1 bit: UART_TX is serialising a frame.
REQ-010 Port TX_P_DATA SHALL be an output reg, DATA_WIDTH bits: byte presented to UART_TX.
REQ-011 Port TX_D_VLD SHALL be an output reg, 1 bit: one-cycle strobe qualifying TX_P_DATA.
REQ-012 Port OVF_ERR SHALL be an output reg, 1 bit: sticky flag, set when a result is dropped.

Function
REQ-013 The block SHALL hold one pending slot per source: RF_PEND with an 8-bit buffer, and ALU_PEND with a 16-bit buffer.
REQ-014 A pending slot SHALL be filled on the edge at which its valid strobe is sampled high and its slot is empty.
REQ-015 A valid strobe arriving while its slot is already full SHALL be discarded, leaving the slot unchanged, and SHALL set OVF_ERR.
REQ-016 OVF_ERR SHALL remain set until reset.
REQ-017 The state machine SHALL have the states IDLE, SEND, WAIT_ACK and WAIT_DONE, plus a registered byte-select: RF, ALU_LO or ALU_HI.
REQ-018 In IDLE with Busy=0, the block SHALL select RF if RF_PEND=1, else ALU_LO if ALU_PEND=1; RF has priority on simultaneous pending.
REQ-019 On that selection the block SHALL move to SEND; otherwise it SHALL stay in IDLE.
REQ-020 In SEND, the block SHALL drive TX_D_VLD=1 for exactly one cycle with TX_P_DATA as follows: RdData buffer for RF, ALU[7:0] for ALU_LO, ALU[15:8] for ALU_HI.
REQ-021 After SEND the block SHALL go to WAIT_ACK.
REQ-022 In WAIT_ACK the block SHALL hold TX_D_VLD=0 and SHALL go to WAIT_DONE when Busy=1.
REQ-023 In WAIT_DONE, when Busy=0, the block SHALL branch on the byte-select:
- RF: clear RF_PEND and go to IDLE.
- ALU_LO: select ALU_HI and go to SEND.
- ALU_HI: clear ALU_PEND and go to IDLE.
REQ-024 The ALU result SHALL always be sent low byte first, high byte second, with no other byte interleaved between them.
REQ-025 A slot SHALL be cleared at the same edge as its final WAIT_DONE exit; a strobe for that source on that same edge SHALL refill the slot and SHALL NOT set OVF_ERR.
REQ-026 TX_P_DATA SHALL hold its last value outside SEND; only TX_D_VLD qualifies it.
REQ-027 Latency: a strobe sampled at edge E while the block is IDLE with Busy=0 and no pending slot SHALL give TX_D_VLD=1 in the cycle after edge E+1.
REQ-028 Incoming strobes SHALL be captured in every state, including while the block is serialising.
REQ-029 A stuck-high Busy SHALL hold the state machine in WAIT_DONE indefinitely, with no timeout.

Reset
REQ-030 With reset=0 at a rising edge, the block SHALL set state=IDLE, RF_PEND=0, ALU_PEND=0, TX_P_DATA=0, TX_D_VLD=0 and OVF_ERR=0.
REQ-031 Reset SHALL override all strobes presented at the same edge.
REQ-032 A reset asserted mid-transfer SHALL abandon the in-flight byte and all pending data, with no resumption after release.

Verification
REQ-033 RF read: RdData=0x5A with a one-cycle RdData_Valid, and the model pulses Busy high 10 cycles after the strobe -> one TX_D_VLD pulse with TX_P_DATA=0x5A, then back to IDLE.
REQ-034 ALU result: ALU_OUT=0xBEEF with OUT_Valid -> TX_D_VLD pulses carrying 0xEF then 0xBE; the second pulse comes only after Busy falls.
REQ-035 Simultaneous: RdData=0x11 and ALU_OUT=0x3344 strobed on the same edge -> byte order 0x11, 0x44, 0x33, with OVF_ERR=0.
REQ-036 Overflow: a second RdData_Valid (0x22) arrives while 0x11 is pending -> only 0x11 is transmitted and OVF_ERR=1 stays set.
REQ-037 Reset mid-ALU: reset=0 during WAIT_DONE of the low byte 0xEF -> no 0xBE is sent, outputs are zero, and OVF_ERR=0.
REQ-038 Edge refill: OUT_Valid (0x0102) on the ALU_HI WAIT_DONE exit edge of a prior result -> 0x02 then 0x01 are sent next, with OVF_ERR=0.
